fifo_word_assembler: RTL and testbench

- Read-side consumer for the team's 8-bit synchronous byte FIFO.
- Pops bytes with the FIFO's empty/rd_en handshake; the FIFO returns data one cycle after a read.
- Packs WORD_BYTES bytes into one wide operand word for the RSA datapath and presents it on a valid/ready interface.

---
 rtl/fifo_word_assembler_pkg.sv | 17 +
 rtl/fifo_word_assembler_idle_timer.sv | 59 +++++
 rtl/fifo_word_assembler.sv | 179 +++++++++++++++++
 tb/tb_fifo_word_assembler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_assembler_pkg.sv
// fifo_word_assembler_pkg
// Shared definitions for the byte-FIFO to wide-word assembler:
//   - asm_state_e : assembler FSM encoding (ASM_FILL / ASM_OUTPUT)
//   - BYTE_W      : width of one FIFO byte lane
//   - DEFAULT_WORD_BYTES / DEFAULT_TIMEOUT_CYCLES : default parameter values
package fifo_word_assembler_pkg;

    typedef enum logic {
        ASM_FILL   = 1'b0,
        ASM_OUTPUT = 1'b1
    } asm_state_e;

    localparam int unsigned BYTE_W                 = 8;
    localparam int unsigned DEFAULT_WORD_BYTES     = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage : fifo_word_assembler_pkg

// File: rtl/fifo_word_assembler_idle_timer.sv
// asm_idle_timer
// Idle-cycle counter used to flush a partially filled word.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the count (wins over en)
//   en       : count one idle cycle
//   tc       : high during the LIMIT-th consecutive enabled cycle
module asm_idle_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Terminal count fires on the last enabled idle cycle.
    always_comb begin
        tc = 1'b0;
        if (en && !clr && (cnt_q == LAST)) begin
            tc = 1'b1;
        end else begin
            tc = 1'b0;
        end
    end

    // Next count: clear, wrap at terminal count, or increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : asm_idle_timer

// File: rtl/fifo_word_assembler.sv
// fifo_word_assembler
// Pops bytes from an 8-bit synchronous FIFO (data returns one cycle after
// fifo_rd_en) and packs WORD_BYTES of them little-endian into one word,
// presented on a valid/ready interface.
// Optional feature macro: ASSEMBLER_TIMEOUT_EN -- flush a partial word after
// TIMEOUT_CYCLES idle cycles (word_partial=1, byte_cnt = valid byte count).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   fifo_empty    : FIFO empty flag
//   fifo_data     : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : FIFO read request (combinational)
//   word_out      : assembled word, first byte in [7:0]
//   word_valid    : word_out holds a complete or flushed word
//   word_ready    : downstream accepts word_out
//   byte_cnt      : bytes captured into the current word
//   word_partial  : current word was flushed short
module fifo_word_assembler
    import fifo_word_assembler_pkg::*;
#(
    parameter int unsigned WORD_BYTES     = DEFAULT_WORD_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [7:0]                   fifo_data,
    output logic                         fifo_rd_en,
    output logic [8*WORD_BYTES-1:0]      word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [4:0]                   byte_cnt,
    output logic                         word_partial
);

    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BYTES);

    asm_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              word_valid_q, word_valid_d;
    logic              word_partial_q, word_partial_d;
    logic              rd_en_s;
    logic              timeout_hit_s;

`ifdef ASSEMBLER_TIMEOUT_EN
    logic idle_en_s;

    // Idle means a started word with nothing requested and nothing in flight.
    always_comb begin
        idle_en_s = 1'b0;
        if ((state_q == ASM_FILL) && (byte_cnt_q != '0) && !rd_pend_q && !rd_en_s) begin
            idle_en_s = 1'b1;
        end else begin
            idle_en_s = 1'b0;
        end
    end

    asm_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk (clk),
        .rst (rst),
        .clr (!idle_en_s),
        .en  (idle_en_s),
        .tc  (timeout_hit_s)
    );
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_hit_s    = 1'b0;
`endif

    // Read issue: only while filling, FIFO not empty and the word not yet
    // fully requested; held low during reset.
    always_comb begin
        rd_en_s = 1'b0;
        if (rst) begin
            rd_en_s = 1'b0;
        end else if ((state_q == ASM_FILL) && !fifo_empty && (issued_cnt_q < FULL_CNT)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state logic: byte capture, fill/flush completion and hand-off.
    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        byte_cnt_d     = byte_cnt_q;
        issued_cnt_d   = issued_cnt_q;
        word_valid_d   = word_valid_q;
        word_partial_d = word_partial_q;
        rd_pend_d      = rd_en_s;

        if (rd_en_s) begin
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
        end else begin
            issued_cnt_d = issued_cnt_q;
        end

        case (state_q)
            ASM_FILL: begin
                if (rd_pend_q) begin
                    // Byte returned by the FIFO lands in lane byte_cnt.
                    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                        if (CNT_W'(i) == byte_cnt_q) begin
                            word_d[i*BYTE_W +: BYTE_W] = fifo_data;
                        end else begin
                            word_d[i*BYTE_W +: BYTE_W] = word_q[i*BYTE_W +: BYTE_W];
                        end
                    end
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if ((byte_cnt_q + CNT_W'(1)) == FULL_CNT) begin
                        state_d      = ASM_OUTPUT;
                        word_valid_d = 1'b1;
                    end else begin
                        state_d      = ASM_FILL;
                    end
                end else if (timeout_hit_s) begin
                    // Flush short; issued_cnt is left as-is until hand-off.
                    state_d        = ASM_OUTPUT;
                    word_valid_d   = 1'b1;
                    word_partial_d = 1'b1;
                end else begin
                    state_d = ASM_FILL;
                end
            end
            ASM_OUTPUT: begin
                if (word_ready) begin
                    state_d        = ASM_FILL;
                    word_d         = '0;
                    byte_cnt_d     = '0;
                    issued_cnt_d   = '0;
                    word_valid_d   = 1'b0;
                    word_partial_d = 1'b0;
                end else begin
                    state_d = ASM_OUTPUT;
                end
            end
            default: begin
                state_d = ASM_FILL;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ASM_FILL;
            word_q         <= '0;
            byte_cnt_q     <= '0;
            issued_cnt_q   <= '0;
            rd_pend_q      <= 1'b0;
            word_valid_q   <= 1'b0;
            word_partial_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            byte_cnt_q     <= byte_cnt_d;
            issued_cnt_q   <= issued_cnt_d;
            rd_pend_q      <= rd_pend_d;
            word_valid_q   <= word_valid_d;
            word_partial_q <= word_partial_d;
        end
    end

    assign fifo_rd_en   = rd_en_s;
    assign word_out     = word_q;
    assign word_valid   = word_valid_q;
    assign byte_cnt     = byte_cnt_q;
    assign word_partial = word_partial_q;

endmodule : fifo_word_assembler

// File: tb/tb_fifo_word_assembler.sv
// tb_fifo_word_assembler
// Scoreboard bench: every byte placed in the FIFO model is folded into an
// expected word that is queued; words leaving the DUT are popped and compared.
module tb_fifo_word_assembler;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [4:0]  byte_cnt;
    logic        word_partial;

    typedef struct {
        logic [31:0] w;
        logic [4:0]  cnt;
        logic        partial;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  src_mem [0:255];
    int          wr_ptr;
    int          rd_ptr;
    logic        hold_empty;

    logic [31:0] acc_w;
    int          acc_n;

    int n_total;
    int n_bad;
    int cyc_n;
    int n_rd;
    int n_valid;
    int rd_run;
    int last_rd_cyc;
    int first_rd;
    int first_val;

    fifo_word_assembler #(
        .WORD_BYTES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .byte_cnt     (byte_cnt),
        .word_partial (word_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered read data, one cycle after rd_en.
    initial begin
        rd_ptr    = 0;
        fifo_data = 8'h00;
    end
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= src_mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end
    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte into the FIFO model; tracked bytes also build expected words.
    task automatic push_byte(input logic [7:0] b, input bit track);
        exp_t e;
        src_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        if (track) begin
            acc_w = acc_w | (32'(b) << (8 * acc_n));
            acc_n++;
            if (acc_n == 4) begin
                e.w = acc_w; e.cnt = 5'd4; e.partial = 1'b0;
                exp_q.push_back(e);
                acc_w = 32'h0; acc_n = 0;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst) begin
            if (fifo_rd_en) begin
                n_rd++;
                if (last_rd_cyc == cyc_n - 1) rd_run++;
                else rd_run = 1;
                last_rd_cyc = cyc_n;
                if (first_rd < 0) first_rd = cyc_n;
            end
            if (word_valid) begin
                n_valid++;
                if (first_val < 0) first_val = cyc_n;
                if (word_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_word", 64'(word_out), 64'hDEAD_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("word_out", 64'(word_out), 64'(e.w));
                        check_val("byte_cnt", 64'(byte_cnt), 64'(e.cnt));
                        check_val("word_partial", 64'(word_partial), 64'(e.partial));
                    end
                end
            end
        end
    endtask

    // One clock: sample at negedge, return just after the next posedge.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            cyc();
            k++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
        cyc();
    endtask

    task automatic wait_valid(input int max_cyc);
        int k;
        k = 0;
        while (!word_valid && k < max_cyc) begin
            cyc();
            k++;
        end
        if (!word_valid) check_val("valid_timeout", 64'(word_valid), 64'd1);
    endtask

    initial begin
        int rd0;
        int v0;
        int k;
        n_total = 0; n_bad = 0; cyc_n = 0; n_rd = 0; n_valid = 0;
        rd_run = 0; last_rd_cyc = -10; first_rd = -1; first_val = -1;
        wr_ptr = 0; hold_empty = 1'b0; acc_w = 32'h0; acc_n = 0;
        rst = 1'b1; word_ready = 1'b0;

        // Reset state
        #2;
        check_val("rst_word_out", 64'(word_out), 64'd0);
        check_val("rst_word_valid", 64'(word_valid), 64'd0);
        check_val("rst_byte_cnt", 64'(byte_cnt), 64'd0);
        check_val("rst_partial", 64'(word_partial), 64'd0);
        check_val("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Test 1: four back-to-back reads, one-cycle valid with ready high
        word_ready = 1'b1;
        rd0 = n_rd; v0 = n_valid; first_rd = -1; first_val = -1;
        push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1); push_byte(8'h44, 1'b1);
        wait_drain(40);
        check_val("t1_rd_count", 64'(n_rd - rd0), 64'd4);
        check_val("t1_rd_run", 64'(rd_run), 64'd4);
        check_val("t1_valid_cycles", 64'(n_valid - v0), 64'd1);
        check_val("t1_latency", 64'(first_val - first_rd), 64'd5);

        // Test 2: backpressure holds the first word, no prefetch
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
        wait_valid(40);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_val("t2_hold_word", 64'(word_out), 64'h04030201);
            check_val("t2_hold_rd_en", 64'(fifo_rd_en), 64'd0);
            check_val("t2_hold_valid", 64'(word_valid), 64'd1);
        end
        word_ready = 1'b1;
        wait_drain(60);

        // Test 3: empty toggling between bytes
        rd0 = n_rd;
        hold_empty = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            hold_empty = 1'b0;
            cyc();
            hold_empty = 1'b1;
            cyc(); cyc();
        end
        hold_empty = 1'b0;
        wait_drain(40);
        check_val("t3_rd_count", 64'(n_rd - rd0), 64'd4);

        // Test 4: reset after two captured bytes
        push_byte(8'hC1, 1'b0); push_byte(8'hC2, 1'b0);
        k = 0;
        while (byte_cnt != 5'd2 && k < 20) begin cyc(); k++; end
        check_val("t4_pre_cnt", 64'(byte_cnt), 64'd2);
        rst = 1'b1;
        #1;
        check_val("t4_rst_word", 64'(word_out), 64'd0);
        check_val("t4_rst_cnt", 64'(byte_cnt), 64'd0);
        check_val("t4_rst_valid", 64'(word_valid), 64'd0);
        push_byte(8'h55, 1'b1); push_byte(8'h66, 1'b1);
        push_byte(8'h77, 1'b1); push_byte(8'h88, 1'b1);
        check_val("t4_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        cyc();
        check_val("t4_rst_rd_en2", 64'(fifo_rd_en), 64'd0);
        check_val("t4_rst_partial", 64'(word_partial), 64'd0);
        rst = 1'b0;
        wait_drain(40);

        // Test 5: partial word, timeout flush or indefinite wait
`ifdef ASSEMBLER_TIMEOUT_EN
        begin
            exp_t e;
            push_byte(8'hDE, 1'b0); push_byte(8'hAD, 1'b0);
            e.w = 32'h0000ADDE; e.cnt = 5'd2; e.partial = 1'b1;
            exp_q.push_back(e);
            wait_drain(60);
        end
`else
        v0 = n_valid;
        push_byte(8'hDE, 1'b1); push_byte(8'hAD, 1'b1);
        for (int i = 0; i < 100; i++) cyc();
        check_val("t5_no_valid", 64'(n_valid - v0), 64'd0);
        check_val("t5_cnt_wait", 64'(byte_cnt), 64'd2);
        push_byte(8'hBE, 1'b1); push_byte(8'hEF, 1'b1);
        wait_drain(40);
`endif

        check_val("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fifo_word_assembler
